// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : UART clocking constants, default-divisor helpers, tick bundle.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned BAUD       = 115_200;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_IDX_W   = $clog2(OVERSAMPLE);

    typedef struct packed {
        logic                os_tick;
        logic                mid_tick;
        logic                bit_tick;
        logic [OS_IDX_W-1:0] os_idx;
    } tick_bundle_t;

    // Divisor in fixed point with frac_w fractional bits, rounded to nearest.
    function automatic longint unsigned div_fixed(input int unsigned frac_w);
        longint unsigned den;
        den = 64'(BAUD) * 64'(OVERSAMPLE);
        return ((64'(CLK_HZ) << frac_w) + (den >> 1)) / den;
    endfunction

    function automatic int unsigned def_div_int(input int unsigned frac_w);
        return 32'(div_fixed(frac_w) >> frac_w);
    endfunction

    function automatic int unsigned def_div_frac(input int unsigned frac_w);
        return 32'(div_fixed(frac_w) & ((64'd1 << frac_w) - 64'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frac_div.sv
`default_nettype none
// ============================================================================
// Module      : uart_frac_div
// Description : Fractional clock-enable divider (counter + carry accumulator).
// Revision    : 1.0
// ============================================================================
module uart_frac_div #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_os_tick,
    output logic              o_tick_nxt
);

    localparam logic [DIV_W:0] c_one = {{DIV_W{1'b0}}, 1'b1};

    logic [DIV_W:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic            r_os_tick;

    logic [FRAC_W:0] w_sum;
    logic [DIV_W:0]  w_period;
    logic            w_wrap;

    // Carry out of the accumulator stretches this interval by one cycle.
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_div_frac};
    assign w_period   = {1'b0, i_div_int} + {{DIV_W{1'b0}}, w_sum[FRAC_W]};
    assign w_wrap     = (r_cnt == (w_period - c_one));
    assign o_tick_nxt = i_en & ~i_clr & w_wrap;
    assign o_os_tick  = r_os_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_os_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_os_tick <= 1'b0;
        end else if (i_en) begin
            if (w_wrap) begin
                r_cnt     <= '0;
                r_acc     <= w_sum[FRAC_W-1:0];
                r_os_tick <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + c_one;
                r_os_tick <= 1'b0;
            end
        end else begin
            r_os_tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Programmable fractional baud tick generator (os/mid/bit ticks).
// Revision    : 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned DEF_DIV_INT  = uart_pkg::def_div_int(FRAC_W),
    parameter int unsigned DEF_DIV_FRAC = uart_pkg::def_div_frac(FRAC_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          phase_clr,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_idx,
    output logic                          div_err
);

    import uart_pkg::*;

    localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] c_idx_pre_mid = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] c_idx_one     = IDX_W'(1);
    localparam logic [DIV_W-1:0] c_div_min     = DIV_W'(2);

    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic              r_div_err;
    logic [IDX_W-1:0]  r_os_idx;
    logic              r_mid_tick;
    logic              r_bit_tick;

    logic w_clr;
    logic w_clamp;
    logic w_tick_nxt;
    logic w_os_tick;

    assign w_clr   = div_load | phase_clr;
    assign w_clamp = (div_int < c_div_min);

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_clr      (w_clr),
        .i_div_int  (r_div_int),
        .i_div_frac (r_div_frac),
        .o_os_tick  (w_os_tick),
        .o_tick_nxt (w_tick_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_int  <= DIV_W'(DEF_DIV_INT);
            r_div_frac <= FRAC_W'(DEF_DIV_FRAC);
            r_div_err  <= 1'b0;
        end else if (div_load) begin
            r_div_int  <= w_clamp ? c_div_min : div_int;
            r_div_frac <= div_frac;
            r_div_err  <= w_clamp;
        end
    end

    // Index and bit/mid strobes are registered on the same edge as os_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_idx   <= '0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (w_clr) begin
            r_os_idx   <= '0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
            if (w_tick_nxt) begin
                r_mid_tick <= (r_os_idx == c_idx_pre_mid);
                if (r_os_idx == c_idx_last) begin
                    r_os_idx   <= '0;
                    r_bit_tick <= 1'b1;
                end else begin
                    r_os_idx <= r_os_idx + c_idx_one;
                end
            end
        end
    end

    assign os_tick  = w_os_tick;
    assign mid_tick = r_mid_tick;
    assign bit_tick = r_bit_tick;
    assign os_idx   = r_os_idx;
    assign div_err  = r_div_err;

endmodule
`default_nettype wire
